// File: rtl/mmio_req_arbiter.sv
// mmio_req_arbiter: shares one MMIO port (read/write, active-low enables)
// between NUM_REQ requesters with round-robin grant and a single operation
// in flight. Read data and write completions are routed back to the owner.
// Optional feature: define MMIO_ARB_WDOG_EN to abort writes whose busy
// phase lasts WDOG_CYCLES cycles (response flagged with OUT_rspErr).
module mmio_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int RD_LAT      = 1,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    IN_reqValid,
  input  logic [NUM_REQ-1:0]    IN_reqWe,
  input  logic [NUM_REQ*32-1:0] IN_reqAddr,
  input  logic [NUM_REQ*32-1:0] IN_reqWData,
  input  logic [NUM_REQ*4-1:0]  IN_reqWMask,
  output logic [NUM_REQ-1:0]    OUT_reqReady,
  output logic [NUM_REQ-1:0]    OUT_rspValid,
  output logic [31:0]           OUT_rspData,
  output logic                  OUT_rspErr,
  output logic                  OUT_mmioRe,
  output logic [31:0]           OUT_mmioRAddr,
  input  logic [31:0]           IN_mmioRData,
  output logic                  OUT_mmioWe,
  output logic [31:0]           OUT_mmioWAddr,
  output logic [31:0]           OUT_mmioWData,
  output logic [3:0]            OUT_mmioWMask,
  input  logic                  IN_mmioWBusy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One counter serves both the read-latency wait and the write watchdog.
  localparam int CNT_W = $clog2(WDOG_CYCLES + 4);

  // S_ISSUE is the single cycle between the grant and the enable-low cycle.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_WR_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               we_op_q, we_op_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               mmio_re_q, mmio_re_d;
  logic               mmio_we_q, mmio_we_d;
`ifdef MMIO_ARB_WDOG_EN
  logic               rsp_err_q, rsp_err_d;
`endif

  logic               arb_found_s;
  logic [IDX_W-1:0]   arb_idx_s;
  int                 arb_cand_s;
  logic               sel_we_s;
  logic [31:0]        sel_addr_s;
  logic [31:0]        sel_wdata_s;
  logic [3:0]         sel_wmask_s;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Round-robin pick: first valid requester at or after rr_q, then mux its request fields.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    arb_cand_s  = 0;
    sel_we_s    = 1'b0;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    sel_wmask_s = 4'h0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_cand_s = int'(rr_q) + i;
      if (arb_cand_s >= NUM_REQ) begin
        arb_cand_s = arb_cand_s - NUM_REQ;
      end else begin
        arb_cand_s = arb_cand_s;
      end
      if (!arb_found_s && IN_reqValid[IDX_W'(arb_cand_s)]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = IDX_W'(arb_cand_s);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx_s == IDX_W'(i)) begin
        sel_we_s    = IN_reqWe[i];
        sel_addr_s  = IN_reqAddr[i*32 +: 32];
        sel_wdata_s = IN_reqWData[i*32 +: 32];
        sel_wmask_s = IN_reqWMask[i*4 +: 4];
      end else begin
        sel_we_s    = sel_we_s;
      end
    end
  end

  // Next-state and registered-output logic; enables default high, pulses default low.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    we_op_d     = we_op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    mmio_re_d   = 1'b1;
    mmio_we_d   = 1'b1;
`ifdef MMIO_ARB_WDOG_EN
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A response pulse in flight blocks the grant for this cycle.
        if (arb_found_s && (rsp_valid_q == '0)) begin
          ready_d = idx_to_onehot(arb_idx_s);
          gnt_d   = arb_idx_s;
          we_op_d = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          wmask_d = sel_wmask_s;
          cnt_d   = '0;
          state_d = S_ISSUE;
          if (arb_idx_s == IDX_W'(NUM_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = arb_idx_s + IDX_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (we_op_q) begin
          mmio_we_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WR_DRAIN;
        end else begin
          mmio_re_d = 1'b0;
          cnt_d     = CNT_W'(RD_LAT);
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // cnt_q reaches zero in the cycle RD_LAT after the re-low cycle.
        if (cnt_q == '0) begin
          rsp_data_d  = IN_mmioRData;
          rsp_valid_d = idx_to_onehot(gnt_q);
          state_d     = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_RD_WAIT;
        end
      end
      S_WR_DRAIN: begin
        // Busy is meaningless during the we-low cycle itself.
        if (!mmio_we_q) begin
          state_d = S_WR_DRAIN;
        end else if (!IN_mmioWBusy) begin
          rsp_valid_d = idx_to_onehot(gnt_q);
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
`ifdef MMIO_ARB_WDOG_EN
          if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
            rsp_valid_d = idx_to_onehot(gnt_q);
            rsp_err_d   = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_WR_DRAIN;
          end
`else
          state_d = S_WR_DRAIN;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      we_op_q     <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      wmask_q     <= 4'h0;
      cnt_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 32'h0000_0000;
      mmio_re_q   <= 1'b1;
      mmio_we_q   <= 1'b1;
`ifdef MMIO_ARB_WDOG_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      we_op_q     <= we_op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mmio_re_q   <= mmio_re_d;
      mmio_we_q   <= mmio_we_d;
`ifdef MMIO_ARB_WDOG_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign OUT_reqReady  = ready_q;
  assign OUT_rspValid  = rsp_valid_q;
  assign OUT_rspData   = rsp_data_q;
  assign OUT_mmioRe    = mmio_re_q;
  assign OUT_mmioRAddr = addr_q;
  assign OUT_mmioWe    = mmio_we_q;
  assign OUT_mmioWAddr = addr_q;
  assign OUT_mmioWData = wdata_q;
  assign OUT_mmioWMask = wmask_q;
`ifdef MMIO_ARB_WDOG_EN
  assign OUT_rspErr    = rsp_err_q;
`else
  assign OUT_rspErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_req_arbiter.sv
// Testbench for mmio_req_arbiter: table of single transactions plus
// hand-written sequences for arbitration order, reset, dropped requests
// and (with MMIO_ARB_WDOG_EN) the write watchdog.
module tb_mmio_req_arbiter;

  localparam int RD_LAT = 1;

  logic        clk;
  logic        rst;
  logic [1:0]  IN_reqValid;
  logic [1:0]  IN_reqWe;
  logic [63:0] IN_reqAddr;
  logic [63:0] IN_reqWData;
  logic [7:0]  IN_reqWMask;
  logic [1:0]  OUT_reqReady;
  logic [1:0]  OUT_rspValid;
  logic [31:0] OUT_rspData;
  logic        OUT_rspErr;
  logic        OUT_mmioRe;
  logic [31:0] OUT_mmioRAddr;
  logic [31:0] IN_mmioRData;
  logic        OUT_mmioWe;
  logic [31:0] OUT_mmioWAddr;
  logic [31:0] OUT_mmioWData;
  logic [3:0]  OUT_mmioWMask;
  logic        IN_mmioWBusy;

  mmio_req_arbiter #(.NUM_REQ(2), .RD_LAT(RD_LAT), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .IN_reqValid(IN_reqValid), .IN_reqWe(IN_reqWe), .IN_reqAddr(IN_reqAddr),
    .IN_reqWData(IN_reqWData), .IN_reqWMask(IN_reqWMask),
    .OUT_reqReady(OUT_reqReady), .OUT_rspValid(OUT_rspValid),
    .OUT_rspData(OUT_rspData), .OUT_rspErr(OUT_rspErr),
    .OUT_mmioRe(OUT_mmioRe), .OUT_mmioRAddr(OUT_mmioRAddr), .IN_mmioRData(IN_mmioRData),
    .OUT_mmioWe(OUT_mmioWe), .OUT_mmioWAddr(OUT_mmioWAddr), .OUT_mmioWData(OUT_mmioWData),
    .OUT_mmioWMask(OUT_mmioWMask), .IN_mmioWBusy(IN_mmioWBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port model: read data valid exactly RD_LAT cycles after re-low, busy for busy_cfg cycles after we-low.
  logic [31:0] rd_val;
  int          busy_cfg;
  int          busy_left;
  logic [3:0]  re_hist;
  initial begin
    re_hist = 4'h0; busy_left = 0; IN_mmioRData = 32'h0000_0000; IN_mmioWBusy = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    re_hist = {re_hist[2:0], ~OUT_mmioRe};
    IN_mmioRData = re_hist[RD_LAT] ? rd_val : 32'hBADB_AD00;
    if (!OUT_mmioWe) begin
      IN_mmioWBusy = 1'b0;
      busy_left = busy_cfg;
    end else if (busy_left > 0) begin
      IN_mmioWBusy = 1'b1;
      busy_left = busy_left - 1;
    end else begin
      IN_mmioWBusy = 1'b0;
    end
  end

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          busy;
    logic [1:0]  exp_ready;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  int   total, bad, cyc;
  int   re_cnt, we_cnt, rdy_cnt, rsp_cnt, both_low;
  int   re_cyc, we_cyc, rdy_cyc, rsp_cyc;
  logic [31:0] re_addr, w_addr, w_data, rsp_data;
  logic [3:0]  w_mask;
  logic [1:0]  rdy_val, rsp_val;
  logic        rsp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    re_cnt = 0; we_cnt = 0; rdy_cnt = 0; rsp_cnt = 0;
    re_cyc = -1; we_cyc = -1; rdy_cyc = -1; rsp_cyc = -1;
    rdy_val = 2'b00; rsp_val = 2'b00; rsp_err = 1'b0;
  endtask

  // Advance one cycle: sample outputs on the falling edge, return just after it.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!OUT_mmioRe) begin re_cnt++; re_cyc = cyc; re_addr = OUT_mmioRAddr; end
    if (!OUT_mmioWe) begin
      we_cnt++; we_cyc = cyc; w_addr = OUT_mmioWAddr; w_data = OUT_mmioWData; w_mask = OUT_mmioWMask;
    end
    if (!OUT_mmioRe && !OUT_mmioWe) both_low++;
    if (OUT_reqReady != 2'b00) begin rdy_cnt++; rdy_cyc = cyc; rdy_val = OUT_reqReady; end
    if (OUT_rspValid != 2'b00) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_val = OUT_rspValid; rsp_data = OUT_rspData; rsp_err = OUT_rspErr;
    end
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_re"},    32'(OUT_mmioRe),    32'd1);
    chk({tag, "_we"},    32'(OUT_mmioWe),    32'd1);
    chk({tag, "_ready"}, 32'(OUT_reqReady),  32'd0);
    chk({tag, "_rspv"},  32'(OUT_rspValid),  32'd0);
    chk({tag, "_err"},   32'(OUT_rspErr),    32'd0);
    chk({tag, "_raddr"}, OUT_mmioRAddr,      32'd0);
    chk({tag, "_wdata"}, OUT_mmioWData,      32'd0);
    chk({tag, "_rdata"}, OUT_rspData,        32'd0);
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    IN_reqWe[r] = we;
    IN_reqAddr[r*32 +: 32] = a;
    IN_reqWData[r*32 +: 32] = d;
    IN_reqWMask[r*4 +: 4] = m;
    IN_reqValid[r] = 1'b1;
  endtask

  task automatic do_txn(input vec_t v);
    int t0;
    clear_mon();
    rd_val = v.rdata;
    busy_cfg = v.busy;
    set_req(v.req, v.we, v.addr, v.wdata, v.wmask);
    for (int i = 0; i < 10 && rdy_cnt == 0; i++) tick();
    t0 = rdy_cyc;
    IN_reqValid = 2'b00;
    for (int i = 0; i < 40 && rsp_cnt == 0; i++) tick();
    tick(); tick();
    chk("ready", 32'(rdy_val), 32'(v.exp_ready));
    chk("ready_cnt", 32'(rdy_cnt), 32'd1);
    if (v.we) begin
      chk("we_cnt", 32'(we_cnt), 32'd1);
      chk("we_time", 32'(we_cyc - t0), 32'd1);
      chk("waddr", w_addr, v.addr);
      chk("wdata", w_data, v.wdata);
      chk("wmask", 32'(w_mask), 32'(v.wmask));
      chk("re_cnt_wr", 32'(re_cnt), 32'd0);
    end else begin
      chk("re_cnt", 32'(re_cnt), 32'd1);
      chk("re_time", 32'(re_cyc - t0), 32'd1);
      chk("raddr", re_addr, v.addr);
      chk("we_cnt_rd", 32'(we_cnt), 32'd0);
      chk("rsp_data", rsp_data, v.exp_data);
    end
    chk("rsp_lat", 32'(rsp_cyc - t0), 32'(v.exp_lat));
    chk("rsp_valid", 32'(rsp_val), 32'(v.exp_ready));
    chk("rsp_pulses", 32'(rsp_cnt), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
  endtask

  task automatic pair_run(output logic [1:0] first, output logic [1:0] second, output int gap);
    int last_re;
    int nrdy;
    first = 2'b00; second = 2'b00; gap = 1000; last_re = -1; nrdy = 0;
    clear_mon();
    rd_val = 32'h0BB0_0001;
    set_req(0, 1'b0, 32'h1100_0000, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h1100_0004, 32'h0, 4'h0);
    for (int i = 0; i < 60 && rsp_cnt < 2; i++) begin
      tick();
      if (OUT_reqReady != 2'b00) begin
        if (nrdy == 0) first = OUT_reqReady;
        else second = OUT_reqReady;
        nrdy++;
        IN_reqValid = IN_reqValid & ~OUT_reqReady;
      end
      if (!OUT_mmioRe) begin
        if (last_re >= 0 && (cyc - last_re) < gap) gap = cyc - last_re;
        last_re = cyc;
      end
    end
    tick(); tick();
  endtask

  initial begin
    logic [1:0] f, s;
    int gap;
    int t0;
    total = 0; bad = 0; cyc = 0; both_low = 0;
    rd_val = 32'h0; busy_cfg = 0;
    IN_reqValid = 2'b00; IN_reqWe = 2'b00; IN_reqAddr = 64'h0;
    IN_reqWData = 64'h0; IN_reqWMask = 8'h0;
    clear_mon();

    vecs[0] = '{0, 1'b0, 32'h1100_BFF8, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2'b01, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h1110_0000, 32'h0000_5555, 4'hF, 32'h0, 3, 2'b10, 6, 32'h0, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h1100_4000, 32'hA5A5_0001, 4'h3, 32'h0, 0, 2'b01, 3, 32'h0, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h0200_0010, 32'h0, 4'h0, 32'h1234_5678, 0, 2'b10, 3, 32'h1234_5678, 1'b0};
    vecs[4] = '{1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 2'b10, 3, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{0, 1'b1, 32'h0200_4008, 32'h8000_0001, 4'h8, 32'h0, 1, 2'b01, 4, 32'h0, 1'b0};

    rst = 1'b1;
    tick(); tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      do_txn(vecs[k]);
    end

    // Reset while a read is in RD_WAIT: outputs return to reset values at once, no late response.
    clear_mon();
    rd_val = 32'h7777_0000;
    set_req(0, 1'b0, 32'h1100_BFF0, 32'h0, 4'h0);
    for (int i = 0; i < 10 && re_cnt == 0; i++) tick();
    chk("mid_re_low", 32'(OUT_mmioRe), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outs("mid");
    IN_reqValid = 2'b00;
    tick(); tick();
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 8; i++) tick();
    chk("mid_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("mid_no_re", 32'(re_cnt), 32'd0);

    // Both requesters read together from rr=0; repeat to show rr came back to 0.
    pair_run(f, s, gap);
    chk("pair_first", 32'(f), 32'd1);
    chk("pair_second", 32'(s), 32'd2);
    chk("pair_re_cnt", 32'(re_cnt), 32'd2);
    chk("pair_gap_ok", 32'(gap >= RD_LAT + 2), 32'd1);
    chk("pair_last_rsp", 32'(rsp_val), 32'd2);
    chk("pair_data", rsp_data, 32'h0BB0_0001);
    pair_run(f, s, gap);
    chk("pair2_first", 32'(f), 32'd1);
    chk("pair2_second", 32'(s), 32'd2);

    // Requester 1 withdraws while requester 0's read is in flight: never granted.
    clear_mon();
    rd_val = 32'h0000_00A5;
    set_req(0, 1'b0, 32'h1100_0100, 32'h0, 4'h0);
    for (int i = 0; i < 10 && rdy_cnt == 0; i++) tick();
    IN_reqValid = 2'b00;
    set_req(1, 1'b0, 32'h1100_0200, 32'h0, 4'h0);
    tick();
    IN_reqValid = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("drop_rdy_cnt", 32'(rdy_cnt), 32'd1);
    chk("drop_re_cnt", 32'(re_cnt), 32'd1);
    chk("drop_rsp_cnt", 32'(rsp_cnt), 32'd1);
    chk("drop_rsp_who", 32'(rsp_val), 32'd1);

`ifdef MMIO_ARB_WDOG_EN
    // Busy stuck high: abort after 8 busy cycles, then serve the queued read.
    clear_mon();
    busy_cfg = 1000;
    rd_val = 32'h0DDC_0FFE;
    set_req(1, 1'b1, 32'h1110_0008, 32'h0000_0001, 4'hF);
    for (int i = 0; i < 10 && rdy_cnt == 0; i++) tick();
    t0 = rdy_cyc;
    IN_reqValid = 2'b00;
    set_req(0, 1'b0, 32'h1100_BFF8, 32'h0, 4'h0);
    for (int i = 0; i < 40 && rsp_cnt == 0; i++) tick();
    chk("wdog_lat", 32'(rsp_cyc - t0), 32'd10);
    chk("wdog_who", 32'(rsp_val), 32'd2);
    chk("wdog_err", 32'(rsp_err), 32'd1);
    for (int i = 0; i < 20 && rdy_cnt < 2; i++) tick();
    chk("wdog_next_rdy", 32'(rdy_val), 32'd1);
    IN_reqValid = 2'b00;
    for (int i = 0; i < 20 && rsp_cnt < 2; i++) tick();
    chk("wdog_next_err", 32'(rsp_err), 32'd0);
    chk("wdog_next_data", rsp_data, 32'h0DDC_0FFE);
`else
    t0 = 0;
`endif

    chk("never_both_low", 32'(both_low + t0 - t0), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
